// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// width-decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Undefined codes 011/110/111 all have funct3[1] set, so they decode as word.
    function automatic logic is_word(input logic [2:0] f3);
        return f3[1];
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rbuf_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        zext;

    always_comb begin
        lane_b    = rbuf_i[{addr_lo_i, 3'b000} +: 8];
        lane_h    = addr_lo_i[1] ? rbuf_i[31:16] : rbuf_i[15:0];
        zext      = (funct3_i == F3_BU) || (funct3_i == F3_HU);
        ld_data_o = rbuf_i;
        if (!is_word(funct3_i)) begin
            if (is_half(funct3_i)) begin
                ld_data_o = zext ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
            end else begin
                ld_data_o = zext ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
        end
    end

    always_comb begin
        st_data_o = rbuf_i;
        if (is_word(funct3_i)) begin
            st_data_o = wdata_i;
        end else if (is_half(funct3_i)) begin
            if (addr_lo_i[1]) begin
                st_data_o[31:16] = wdata_i[15:0];
            end else begin
                st_data_o[15:0] = wdata_i[15:0];
            end
        end else begin
            st_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        end
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a single-port word memory. Define LSU_MISALIGN_TRAP_EN
// to answer misaligned halfword/word requests with rsp_err instead of accessing memory.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    localparam int unsigned IW = idx_width(MEM_WORDS);

    state_e      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        err_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [31:0] mem_a_q;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic        misalign;
    logic        unused_addr;

    assign unused_addr = ^req_addr;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = is_word(req_funct3) ? (req_addr[1:0] != 2'b00)
                                          : (is_half(req_funct3) && req_addr[0]);
    assign rsp_err  = err_q;
`else
    assign misalign = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // Lane logic works from the captured request and rbuf, so rsp_rdata stays
    // stable for as long as RESP is held.
    lsu_align u_align (
        .rbuf_i    (rbuf_q),
        .wdata_i   (wdata_q),
        .funct3_i  (f3_q),
        .addr_lo_i (addr_lo_q),
        .ld_data_o (ld_data),
        .st_data_o (st_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_lo_q   <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            mem_a_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        addr_lo_q   <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        mem_a_q     <= 32'(req_addr[2 +: IW]);
                        req_ready_q <= 1'b0;
                        err_q       <= misalign;
                        if (misalign) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else if (req_we && is_word(req_funct3)) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    rbuf_q <= mem_RD;
                    if (we_q) begin
                        state_q <= WRITE;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = (we_q || err_q) ? '0 : ld_data;
    assign mem_A     = mem_a_q;
    assign mem_WE    = (state_q == WRITE) && !rst;
    assign mem_WD    = (state_q == WRITE) ? st_data : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed plan vectors plus random
// traffic against an arithmetic reference model and a shadow memory.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    assign mem_RD = mem[mem_A[9:0]];

    always @(posedge clk) begin
        if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % m_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Byte offset of the accessed lane once low bits below the access size are dropped.
    function automatic int unsigned m_off(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = m_size(f3);
        return (sz == 4) ? 0 : ((a % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] m_mask(input logic [2:0] f3);
        int unsigned sz = m_size(f3);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] msk = m_mask(f3);
        logic [31:0] v   = (w >> (8 * m_off(f3, a))) & msk;
        if (m_size(f3) < 4 && f3 < 3'd4 && v > (msk >> 1)) v = v | ~msk;
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] wd);
        logic [31:0] msk = m_mask(f3);
        int unsigned sh  = 8 * m_off(f3, a);
        return (w & ~(msk << sh)) | ((wd & msk) << sh);
    endfunction

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold);
        int unsigned idx    = (addr >> 2) % 1024;
        logic        mis    = m_misaligned(f3, addr);
        logic [31:0] old_w  = ref_mem[idx];
        int          e_lat  = mis ? 1 : (!we ? 2 : (m_size(f3) == 4 ? 2 : 3));
        int          e_wcnt = (mis || !we) ? 0 : 1;
        int          e_wcyc = (m_size(f3) == 4) ? 1 : 2;
        logic [31:0] e_rd   = (mis || we) ? 32'h0 : m_load(f3, addr, old_w);
        logic [31:0] e_wd   = m_store(f3, addr, old_w, wd);
        int          k;
        int          wcnt = 0;
        int          wcyc = 0;
        logic [31:0] got_a = '0;
        logic [31:0] got_wd = '0;
        logic [31:0] held;

        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (k = 1; k <= 20; k++) begin
            if (mem_WE === 1'b1) begin
                wcnt++;
                wcyc   = k;
                got_a  = mem_A;
                got_wd = mem_WD;
            end
            if (rsp_valid === 1'b1) break;
            @(posedge clk); #1;
        end
        chk("latency", 32'(k), 32'(e_lat));
        chk("we_count", 32'(wcnt), 32'(e_wcnt));
        if (e_wcnt == 1) begin
            chk("we_cycle", 32'(wcyc), 32'(e_wcyc));
            chk("mem_A", got_a, 32'(idx));
            chk("mem_WD", got_wd, e_wd);
            ref_mem[idx] = e_wd;
        end
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mis});
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, held);
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_we", {31'b0, mem_WE}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        we;
        logic [2:0]  st_codes [6];
        st_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[7]     = 32'h80F0_1020;
        ref_mem[7] = 32'h80F0_1020;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'b0, mem_WE}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_mem_A", mem_A, 32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);
        @(posedge clk); #1;

        // Plan vectors, including the literal values they name.
        chk("plan_lw", m_load(3'b010, 32'h1C, ref_mem[7]), 32'h80F0_1020);
        chk("plan_lb", m_load(3'b000, 32'h1F, ref_mem[7]), 32'hFFFF_FF80);
        chk("plan_lh", m_load(3'b001, 32'h1E, ref_mem[7]), 32'hFFFF_80F0);
        chk("plan_sb", m_store(3'b000, 32'h1D, ref_mem[7], 32'h1234_56AB), 32'h80F0_AB20);
        run_req(1'b0, 3'b010, 32'h0000_001C, 32'h0, 0);
        run_req(1'b0, 3'b000, 32'h0000_001F, 32'h0, 0);
        run_req(1'b0, 3'b100, 32'h0000_001F, 32'h0, 0);
        run_req(1'b0, 3'b001, 32'h0000_001E, 32'h0, 0);
        run_req(1'b0, 3'b101, 32'h0000_001C, 32'h0, 0);
        run_req(1'b0, 3'b010, 32'h0000_001E, 32'h0, 0);
        run_req(1'b1, 3'b000, 32'h0000_001D, 32'h1234_56AB, 0);
        chk("plan_sb_mem", mem[7], 32'h80F0_AB20);
        run_req(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 0);
        chk("plan_sw_mem", mem[8], 32'hDEAD_BEEF);
        run_req(1'b1, 3'b001, 32'h0000_0032, 32'hCAFE_5A5A, 0);
        run_req(1'b1, 3'b001, 32'h0000_0033, 32'h1111_2222, 0);

        // Reset landing on the WRITE cycle of a byte store.
        chk("rstw_ready", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0045;
        req_wdata  = 32'h0000_00EE;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        @(posedge clk); #1;
        chk("rstw_in_write", {31'b0, mem_WE}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_we_gated", {31'b0, mem_WE}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstw_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstw_mem", mem[17], ref_mem[17]);

        // Backpressure, then an immediate follow-on request.
        run_req(1'b0, 3'b010, 32'h0000_001C, 32'h0, 3);
        run_req(1'b0, 3'b001, 32'h0000_0022, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            we = $urandom_range(0, 1);
            f3 = we ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom;
            run_req(we, f3, a, $urandom, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit that sits between the RV32I core's execute stage and the word-addressed data memory, acting as the initiator on the memory's single-port A/WD/WE/RD interface. It accepts one load or store request at a time, performs byte/halfword lane extraction with sign or zero extension for loads, and read-modify-write merging for sub-word stores. It returns the result to the core over a valid/ready response handshake.

## Interface
- MEM_WORDS, 1024: data memory depth in 32-bit words. Word index = addr[2 +: $clog2(MEM_WORDS)], wrapping modulo depth.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load result after extension; 0 for stores.
- rsp_err  out  1  misaligned access (see Configuration).
- mem_A  out  32  memory word index, zero-extended.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable, sampled by memory at clk edge.
- mem_RD  in  32  combinational memory read data for mem_A.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, capture we/funct3/addr/wdata. Next state: misaligned (trap build) -> RESP with err; LW/LB/LH/LBU/LHU/SB/SH -> READ; SW -> WRITE.
- READ: mem_A = captured word index; register mem_RD into rbuf. Loads -> RESP; SB/SH -> WRITE.
- WRITE: mem_WE=1, mem_A = word index. SW: mem_WD = wdata. SB: rbuf with byte lane addr[1:0] replaced by wdata[7:0]. SH: rbuf with halfword lane addr[1] replaced by wdata[15:0]. Next: RESP.
- RESP: rsp_valid=1 with rdata/err stable. On rsp_ready -> IDLE.
- Load extraction from rbuf: byte lane addr[1:0], halfword lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Bytes are never misaligned.
- Undefined funct3 (011, 110, 111) is treated as LW/SW.

## Timing
- Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_A=0; mem_WD=0; mem_WE=0; rbuf=0.
- Request accepted in cycle T. rsp_valid is first asserted at:
  - LW / loads: T+2.
  - SW: T+2, with mem_WE high in T+1.
  - SB/SH: T+3, with read in T+1 and mem_WE high in T+2.
  - Trapped misaligned: T+1, with no memory access.
- mem_WE = (state==WRITE) && !rst. Asserting rst during WRITE suppresses the write, and the unit is in IDLE the next cycle.
- mem_WE is never high outside WRITE. It is high for exactly one cycle per store.
- Back-to-back: a new request is accepted the cycle after the RESP handshake. There is no overlap.
- rsp_ready low: rsp_valid and rsp_rdata hold indefinitely, and req_ready stays 0.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests skip memory and respond with rsp_err=1 and rsp_rdata=0.
- LSU_MISALIGN_TRAP_EN undefined: rsp_err is tied to 0. Low address bits are ignored for alignment: a halfword uses lane addr[1], and a word uses the containing word. The access proceeds normally.

## Structure
- lsu_pkg holds the funct3 localparams, the state enum typedef, and the MEM_WORDS-derived index-width function.
- Sub-module lsu_align (combinational):
  - Load path: rbuf + funct3 + addr[1:0] -> extended rdata.
  - Store path: rbuf + wdata + funct3 + addr[1:0] -> merged WD.
- lsu_mem_master keeps the FSM, capture registers, and handshakes.

## Test plan
- Memory word 7 = 0x80F01020; LW addr 0x1C -> rsp_valid at T+2, rsp_rdata 0x80F01020, err 0, mem_WE never high.
- LB addr 0x1F -> 0xFFFFFF80; LBU addr 0x1F -> 0x00000080; LH addr 0x1E -> 0xFFFF80F0; LHU addr 0x1C -> 0x00001020.
- SB addr 0x1D, wdata 0x123456AB -> mem_WE one cycle at T+2 with mem_A=7, mem_WD=0x80F0AB20; SW addr 0x20, wdata 0xDEADBEEF -> mem_WE at T+1 with mem_A=8.
- LW addr 0x1E:
  - Trap build: rsp_err=1 at T+1, rdata 0, no mem_WE.
  - Non-trap build: rdata 0x80F01020, err 0.
- rst asserted in SB's WRITE cycle -> mem_WE stays 0 and memory is unchanged; next cycle req_ready=1 and rsp_valid=0.
- rsp_ready held low 3 cycles after LW -> rsp_valid and rsp_rdata stable and req_ready 0; after the handshake, a second request is accepted the next cycle.
